uart_word_tx: RTL and testbench

Parametrised UART transmitter that serialises one multi-byte word into a sequence of standard UART frames (start, data LSB-first, optional parity, stop). It is the synthesisable successor of the hand-built serial stimulus used to load the pipeline over UART. It sits between the debug unit (word source) and the `o_tx` pad. Frame format, byte count and byte order are compile-time selectable.

---
 rtl/uart_word_tx.sv | 139 +++++++++++++
 tb/tb_uart_word_tx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx.sv
// UART transmitter that sends one WORD_BYTES-wide word as back-to-back frames
// (start, LSB-first data, optional parity, stop bits). Byte order is set at compile time.
module uart_word_tx #(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int BAUD_RATE      = 9600,
    parameter int DATA_BITS      = 8,
    parameter int WORD_BYTES     = 4,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1,
    parameter int MSB_BYTE_FIRST = 1
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_start,
    input  logic [WORD_BYTES*DATA_BITS-1:0]  i_word,
    output logic                             o_tx,
    output logic                             o_busy,
    output logic                             o_done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int WORD_W       = WORD_BYTES * DATA_BITS;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_BITS);
    localparam int BYTE_W       = $clog2(WORD_BYTES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CNT_W-1:0]       baud_cnt;
    logic [IDX_W-1:0]       bit_idx;
    logic [BYTE_W-1:0]      byte_cnt;
    logic [WORD_W-1:0]      shift_reg;
    logic [DATA_BITS-1:0]   cur_byte;
    logic                   bit_end;
    logic                   last_data;
    logic                   last_stop;
    logic                   last_byte;
    logic                   frame_end;
    logic                   tx_next;

    // The byte on the line is always taken from the leading end of the shift register
    if (MSB_BYTE_FIRST != 0) begin : g_msb_first
        assign cur_byte = shift_reg[WORD_W-1 -: DATA_BITS];
    end else begin : g_lsb_first
        assign cur_byte = shift_reg[DATA_BITS-1:0];
    end

    assign bit_end   = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign last_data = (bit_idx == IDX_W'(DATA_BITS - 1));
    assign last_stop = (bit_idx == IDX_W'(STOP_BITS - 1));
    assign last_byte = (byte_cnt == BYTE_W'(WORD_BYTES - 1));
    assign frame_end = (state == S_STOP) && bit_end && last_stop;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tx_next    = 1'b1;
        case (state)
            S_IDLE: begin
                if (i_start) state_next = S_START;
            end
            S_START: begin
                tx_next = 1'b0;
                if (bit_end) state_next = S_DATA;
            end
            S_DATA: begin
                tx_next = cur_byte[bit_idx];
                if (bit_end && last_data) state_next = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                tx_next = (PARITY == 1) ? ~^cur_byte : ^cur_byte;
                if (bit_end) state_next = S_STOP;
            end
            S_STOP: begin
                if (frame_end) state_next = last_byte ? S_IDLE : S_START;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs lag the state by one cycle so o_tx comes straight from a flop
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_cnt <= '0;
            o_tx     <= 1'b1;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            o_tx   <= tx_next;
            o_busy <= (state != S_IDLE);
            o_done <= (state == S_IDLE) && o_busy;

            if (state == S_IDLE || state_next != state || bit_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end

            if (state_next != state) begin
                bit_idx <= '0;
            end else if (bit_end) begin
                bit_idx <= bit_idx + 1'b1;
            end

            if (state == S_IDLE && i_start) begin
                byte_cnt <= '0;
            end else if (frame_end) begin
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (state == S_IDLE && i_start) begin
            shift_reg <= i_word;
        end else if (frame_end) begin
            shift_reg <= (MSB_BYTE_FIRST != 0) ? (shift_reg << DATA_BITS)
                                               : (shift_reg >> DATA_BITS);
        end
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: four instances cover 8N1 MSB-first, 8N1 LSB-first,
// 8E2 and 8O2; line bits are predicted into a queue and checked at bit centres.
module tb_uart_word_tx;

    localparam int CPB = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  start_v = '0;
    logic [31:0] word = '0;
    wire  [3:0]  tx_v;
    wire  [3:0]  busy_v;
    wire  [3:0]  done_v;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   done_cnt [4] = '{0, 0, 0, 0};
    int   done_cyc [$];
    logic exp_q [$];

    typedef struct {
        int          sel;
        logic [31:0] word;
        logic [31:0] line;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    uart_word_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .WORD_BYTES(4),
                   .PARITY(0), .STOP_BITS(1), .MSB_BYTE_FIRST(1)) u0 (
        .i_clk(clk), .i_reset(rst), .i_start(start_v[0]), .i_word(word),
        .o_tx(tx_v[0]), .o_busy(busy_v[0]), .o_done(done_v[0]));

    uart_word_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .WORD_BYTES(4),
                   .PARITY(0), .STOP_BITS(1), .MSB_BYTE_FIRST(0)) u1 (
        .i_clk(clk), .i_reset(rst), .i_start(start_v[1]), .i_word(word),
        .o_tx(tx_v[1]), .o_busy(busy_v[1]), .o_done(done_v[1]));

    uart_word_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .WORD_BYTES(4),
                   .PARITY(2), .STOP_BITS(2), .MSB_BYTE_FIRST(1)) u2 (
        .i_clk(clk), .i_reset(rst), .i_start(start_v[2]), .i_word(word),
        .o_tx(tx_v[2]), .o_busy(busy_v[2]), .o_done(done_v[2]));

    uart_word_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .WORD_BYTES(4),
                   .PARITY(1), .STOP_BITS(2), .MSB_BYTE_FIRST(1)) u3 (
        .i_clk(clk), .i_reset(rst), .i_start(start_v[3]), .i_word(word),
        .o_tx(tx_v[3]), .o_busy(busy_v[3]), .o_done(done_v[3]));

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 4; i++) begin
            if (done_v[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
        end
        if (done_v[0] === 1'b1) done_cyc.push_back(cyc);
    end

    function automatic int par_of(input int s);
        case (s)
            2:       return 2;
            3:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int stop_of(input int s);
        return (s >= 2) ? 2 : 1;
    endfunction

    function automatic int frame_bits(input int s);
        return 1 + 8 + ((par_of(s) != 0) ? 1 : 0) + stop_of(s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Predict the line bits of a word, bytes given in the order they leave the pin
    task automatic push_word(input int s, input logic [31:0] line);
        logic [7:0] b;
        for (int k = 0; k < 4; k++) begin
            b = line[31-8*k -: 8];
            exp_q.push_back(1'b0);
            for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
            if (par_of(s) == 2) exp_q.push_back(^b);
            if (par_of(s) == 1) exp_q.push_back(~^b);
            for (int i = 0; i < stop_of(s); i++) exp_q.push_back(1'b1);
        end
    endtask

    task automatic start_word(input int s, input logic [31:0] w);
        word = w;
        start_v[s] = 1'b1;
        tick();
        start_v[s] = 1'b0;
        chk("tx_at_accept", tx_v[s], 1);
        chk("busy_at_accept", busy_v[s], 0);
        tick();
        chk("tx_fall", tx_v[s], 0);
        chk("busy_rise", busy_v[s], 1);
    endtask

    // Called at the o_tx falling edge; walks the whole word cycle by cycle
    task automatic recv_word(input int s, input int poke_off, input int abort_off);
        int   total;
        logic e;
        total = 4 * frame_bits(s) * CPB;
        for (int off = 1; off <= total; off++) begin
            tick();
            if (off == poke_off) begin
                word = 32'hFFFF_FFFF;
                start_v[s] = 1'b1;
            end
            if (off == poke_off + 1) start_v[s] = 1'b0;
            if (off == abort_off) begin
                rst = 1'b1;
                #1;
                chk("abort_tx", tx_v[s], 1);
                chk("abort_busy", busy_v[s], 0);
                chk("abort_done", done_v[s], 0);
                tick();
                tick();
                rst = 1'b0;
                exp_q.delete();
                return;
            end
            if (off % CPB == CPB / 2) begin
                if (exp_q.size() == 0) begin
                    chk("queue_empty", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("line_bit_u%0d_%0d", s, off / CPB), tx_v[s], e);
                end
            end
            if (off == total - 1) begin
                chk("done_early", done_v[s], 0);
                chk("busy_before_end", busy_v[s], 1);
            end
            if (off == total) begin
                chk("done_pulse", done_v[s], 1);
                chk("busy_fall", busy_v[s], 0);
                chk("tx_idle_end", tx_v[s], 1);
            end
        end
        chk("queue_leftover", exp_q.size(), 0);
    endtask

    initial begin
        int d0;
        int n0;
        int stray;

        vecs[0] = '{0, 32'h006C_6F6D, 32'h006C_6F6D};
        vecs[1] = '{1, 32'h006C_6F6D, 32'h6D6F_6C00};
        vecs[2] = '{2, 32'h006C_6F6D, 32'h006C_6F6D};
        vecs[3] = '{3, 32'h006C_6F6D, 32'h006C_6F6D};
        vecs[4] = '{0, 32'hA501_5AFF, 32'hA501_5AFF};
        vecs[5] = '{1, 32'h1234_5678, 32'h7856_3412};
        vecs[6] = '{2, 32'hFF00_C381, 32'hFF00_C381};

        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            chk("reset_tx", tx_v[i], 1);
            chk("reset_busy", busy_v[i], 0);
            chk("reset_done", done_v[i], 0);
        end
        rst = 1'b0;
        repeat (2) tick();
        chk("idle_tx", tx_v[0], 1);

        for (int v = 0; v < 7; v++) begin
            d0 = done_cnt[vecs[v].sel];
            push_word(vecs[v].sel, vecs[v].line);
            start_word(vecs[v].sel, vecs[v].word);
            recv_word(vecs[v].sel, -5, -1);
            tick();
            chk("done_one_cycle", done_v[vecs[v].sel], 0);
            chk("done_count", done_cnt[vecs[v].sel] - d0, 1);
            repeat (3) tick();
        end

        // Start request during a transfer is ignored and not queued
        d0 = done_cnt[0];
        push_word(0, 32'h006C_6F6D);
        start_word(0, 32'h006C_6F6D);
        recv_word(0, 150, -1);
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) stray++;
        end
        chk("no_second_transfer", stray, 0);
        chk("poke_done_count", done_cnt[0] - d0, 1);

        // Asynchronous abort during the data bits of byte 2
        d0 = done_cnt[0];
        push_word(0, 32'h006C_6F6D);
        start_word(0, 32'h006C_6F6D);
        recv_word(0, -5, 2 * 10 * CPB + 35);
        tick();
        chk("abort_no_done", done_cnt[0] - d0, 0);
        chk("abort_line_idle", tx_v[0], 1);
        push_word(0, 32'h006C_6F6D);
        start_word(0, 32'h006C_6F6D);
        recv_word(0, -5, -1);
        tick();
        chk("restart_done_count", done_cnt[0] - d0, 1);
        repeat (3) tick();

        // Start held high: second word begins in the o_done cycle
        d0 = done_cnt[0];
        n0 = done_cyc.size();
        push_word(0, 32'h006C_6F6D);
        word = 32'h006C_6F6D;
        start_v[0] = 1'b1;
        tick();
        chk("hold_busy_at_accept", busy_v[0], 0);
        tick();
        chk("hold_tx_fall", tx_v[0], 0);
        recv_word(0, -5, -1);
        tick();
        chk("second_fall", tx_v[0], 0);
        chk("second_busy", busy_v[0], 1);
        start_v[0] = 1'b0;
        push_word(0, 32'h006C_6F6D);
        recv_word(0, -5, -1);
        repeat (20) tick();
        chk("hold_done_count", done_cnt[0] - d0, 2);
        chk("hold_done_log", done_cyc.size() - n0, 2);
        if (done_cyc.size() - n0 == 2) begin
            chk("done_spacing", done_cyc[n0+1] - done_cyc[n0], 401);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
